// File: rtl/dut_exec_stage.sv
// Execute stage: accepts a stimulus word, drives it onto the DUT, then waits
// for a cycle count or a masked trigger condition (with timeout) and emits
// one result word per vector over a valid/ready handshake.
module dut_exec_stage #(
    parameter int unsigned STF_WIDTH   = 24,
    parameter int unsigned RTF_WIDTH   = 24,
    parameter int unsigned CYCLE_RANGE = 5,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [STF_WIDTH+CYCLE_RANGE+1:0]   in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [RTF_WIDTH-1:0]               trigger_mask,
    input  logic                               abort,
    output logic [STF_WIDTH-1:0]               mosi_data,
    input  logic [RTF_WIDTH-1:0]               miso_data,
    output logic                               dut_clk_en,
    output logic [RTF_WIDTH+CYCLE_RANGE:0]     out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy,
    output logic [CNT_WIDTH-1:0]               vec_count
);

    localparam int unsigned OutW = RTF_WIDTH + CYCLE_RANGE + 1;

    localparam logic [1:0] ModeCount   = 2'b00;
    localparam logic [1:0] ModeTrigAny = 2'b01;
    localparam logic [1:0] ModeTrigAll = 2'b10;
    localparam logic [1:0] ModeTrigEdg = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    state_e                 state_q;
    logic [STF_WIDTH-1:0]   mosi_q;
    logic [CYCLE_RANGE-1:0] cyc_q;
    logic [CYCLE_RANGE-1:0] cnt_q;
    logic [1:0]             mode_q;
    logic [RTF_WIDTH-1:0]   miso_prev_q;
    logic [OutW-1:0]        out_data_q;
    logic                   out_valid_q;
    logic [OutW-1:0]        pend_q;
    logic [CNT_WIDTH-1:0]   vec_count_q;

    logic [RTF_WIDTH-1:0]   masked;
    logic                   trig;
    logic                   run_done;
    logic                   run_timeout;
    logic                   slot_free;
    logic [OutW-1:0]        capture;

    // Trigger evaluation and completion capture for the current RUN cycle.
    always_comb begin
        masked = miso_data & trigger_mask;
        trig   = 1'b0;
        unique case (mode_q)
            ModeCount:   trig = 1'b0;
            ModeTrigAny: trig = |masked;
            ModeTrigAll: trig = (masked == trigger_mask);
            ModeTrigEdg: trig = |(masked & ~miso_prev_q);
            default:     trig = 1'b0;
        endcase
        // Trigger wins over a coincident count hit, so timeout only flags a missed trigger.
        run_done    = trig || (cnt_q == cyc_q);
        run_timeout = (mode_q != ModeCount) && !trig;
        slot_free   = !out_valid_q || out_ready;
        capture     = {miso_data, cnt_q, run_timeout};
    end

    // Previous DUT response, sampled every cycle for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miso_prev_q <= '0;
        end else begin
            miso_prev_q <= miso_data;
        end
    end

    // Control FSM with the output slot, pending result and vector counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            mosi_q      <= '0;
            cyc_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= ModeCount;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            pend_q      <= '0;
            vec_count_q <= '0;
        end else begin
            // A result load below overrides this clear for back-to-back output.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (in_valid && !abort) begin
                        mosi_q  <= in_data[STF_WIDTH+CYCLE_RANGE+1:CYCLE_RANGE+2];
                        cyc_q   <= in_data[CYCLE_RANGE+1:2];
                        mode_q  <= in_data[1:0];
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (run_done) begin
                        if (slot_free) begin
                            out_data_q  <= capture;
                            out_valid_q <= 1'b1;
                            vec_count_q <= vec_count_q + 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            pend_q  <= capture;
                            state_q <= StHold;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHold: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (slot_free) begin
                        out_data_q  <= pend_q;
                        out_valid_q <= 1'b1;
                        vec_count_q <= vec_count_q + 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign dut_clk_en = (state_q == StRun);
    assign mosi_data  = mosi_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign vec_count  = vec_count_q;

endmodule

// File: tb/tb_dut_exec_stage.sv
// Directed bench for dut_exec_stage: a vector table for single-vector timing
// and trigger behaviour, plus hand sequences for backpressure, abort and reset.
module tb_dut_exec_stage;

    localparam int STF = 24;
    localparam int RTF = 24;
    localparam int CR  = 5;
    localparam int CW  = 16;

    logic                clock;
    logic                reset;
    logic [STF+CR+1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic [RTF-1:0]      trigger_mask;
    logic                abort;
    logic [STF-1:0]      mosi_data;
    logic [RTF-1:0]      miso_data;
    logic                dut_clk_en;
    logic [RTF+CR:0]     out_data;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic [CW-1:0]       vec_count;

    int n_checks;
    int n_err;

    dut_exec_stage #(
        .STF_WIDTH  (STF),
        .RTF_WIDTH  (RTF),
        .CYCLE_RANGE(CR),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .trigger_mask(trigger_mask),
        .abort       (abort),
        .mosi_data   (mosi_data),
        .miso_data   (miso_data),
        .dut_clk_en  (dut_clk_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .vec_count   (vec_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]     mode;
        logic [CR-1:0]  cyc;
        logic [STF-1:0] st;
        logic [RTF-1:0] mask;
        logic [RTF-1:0] miso_a;  // before accept and early RUN cycles
        logic [RTF-1:0] miso_b;  // from RUN cycle index sw onward
        int             sw;
        logic [CR-1:0]  exp_el;
        logic           exp_to;
        logic [RTF-1:0] exp_res;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [1:0] mode, input logic [CR-1:0] cyc,
                        input logic [STF-1:0] st);
        chk("in_ready_before_send", 64'(in_ready), 64'd1);
        in_data  = {st, cyc, mode};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (out_valid) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic wait_hold(input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (busy && !dut_clk_en) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        bit found;
        logic [CW-1:0] base;
        bit seen;

        n_checks = 0;
        n_err    = 0;

        //            mode   cyc    st         mask       miso_a     miso_b    sw  el     to    res
        tbl[0] = '{2'b00, 5'd3,  24'hABCDEF, 24'h000000, 24'h123456, 24'h123456, 0, 5'd3,  1'b0, 24'h123456};
        tbl[1] = '{2'b00, 5'd0,  24'h000001, 24'h000000, 24'h00AA55, 24'h00AA55, 0, 5'd0,  1'b0, 24'h00AA55};
        tbl[2] = '{2'b01, 5'd10, 24'h0F0F0F, 24'h000001, 24'h000000, 24'h000001, 2, 5'd2,  1'b0, 24'h000001};
        tbl[3] = '{2'b10, 5'd5,  24'h111111, 24'h0000FF, 24'h00000F, 24'h00000F, 0, 5'd5,  1'b1, 24'h00000F};
        tbl[4] = '{2'b10, 5'd6,  24'h222222, 24'h0000F0, 24'h000000, 24'h0000F3, 1, 5'd1,  1'b0, 24'h0000F3};
        tbl[5] = '{2'b11, 5'd4,  24'h333333, 24'h000010, 24'h000030, 24'h000030, 0, 5'd4,  1'b1, 24'h000030};
        tbl[6] = '{2'b11, 5'd9,  24'h444444, 24'h000010, 24'h000000, 24'h000010, 3, 5'd3,  1'b0, 24'h000010};
        tbl[7] = '{2'b01, 5'd2,  24'h555555, 24'h800000, 24'h000000, 24'h800000, 2, 5'd2,  1'b0, 24'h800000};
        tbl[8] = '{2'b00, 5'd31, 24'h666666, 24'h000000, 24'h5A5A5A, 24'h5A5A5A, 0, 5'd31, 1'b0, 24'h5A5A5A};
        tbl[9] = '{2'b01, 5'd7,  24'h777777, 24'h000003, 24'h000002, 24'h000002, 0, 5'd0,  1'b0, 24'h000002};

        reset        = 1'b1;
        in_data      = '0;
        in_valid     = 1'b0;
        trigger_mask = '0;
        abort        = 1'b0;
        miso_data    = '0;
        out_ready    = 1'b1;
        repeat (3) tick();

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_mosi", 64'(mosi_data), 64'd0);
        chk("rst_vec_count", 64'(vec_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_clk_en", 64'(dut_clk_en), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Table of single vectors, consumer always ready.
        for (int i = 0; i < 10; i++) begin
            trigger_mask = tbl[i].mask;
            miso_data    = tbl[i].miso_a;
            repeat (2) tick();
            send(tbl[i].mode, tbl[i].cyc, tbl[i].st);
            lat = -1;
            for (int k = 0; k < 40; k++) begin
                miso_data = (k >= tbl[i].sw) ? tbl[i].miso_b : tbl[i].miso_a;
                if (k == 0) begin
                    chk($sformatf("v%0d_run_flags", i), {61'd0, dut_clk_en, busy, in_ready},
                        64'b110);
                end
                tick();
                if (out_valid) begin
                    lat = k + 1;
                    break;
                end
            end
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(int'(tbl[i].exp_el) + 1));
            chk($sformatf("v%0d_result", i), 64'(out_data[RTF+CR:CR+1]), 64'(tbl[i].exp_res));
            chk($sformatf("v%0d_elapsed", i), 64'(out_data[CR:1]), 64'(tbl[i].exp_el));
            chk($sformatf("v%0d_timeout", i), 64'(out_data[0]), 64'(tbl[i].exp_to));
            chk($sformatf("v%0d_mosi", i), 64'(mosi_data), 64'(tbl[i].st));
        end
        tick();
        chk("tbl_valid_cleared", 64'(out_valid), 64'd0);
        chk("tbl_vec_count", 64'(vec_count), 64'd10);

        // Backpressure: second vector parks in HOLD until the slot frees.
        base         = vec_count;
        out_ready    = 1'b0;
        trigger_mask = '0;
        miso_data    = 24'hAAAAAA;
        send(2'b00, 5'd1, 24'h111111);
        wait_valid(10, lat);
        chk("bp_a_latency", 64'(lat), 64'd2);
        chk("bp_a_data", 64'(out_data), 64'({24'hAAAAAA, 5'd1, 1'b0}));
        chk("bp_a_count", 64'(vec_count), 64'(base + 16'd1));
        miso_data = 24'hBBBBBB;
        send(2'b00, 5'd2, 24'h222222);
        wait_hold(10, found);
        chk("bp_hold_reached", 64'(found), 64'd1);
        repeat (2) tick();
        chk("bp_hold_flags", {61'd0, dut_clk_en, busy, in_ready}, 64'b010);
        chk("bp_hold_a_kept", 64'(out_data), 64'({24'hAAAAAA, 5'd1, 1'b0}));
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_b_data", 64'(out_data), 64'({24'hBBBBBB, 5'd2, 1'b0}));
        chk("bp_b_valid", 64'(out_valid), 64'd1);
        chk("bp_b_idle", 64'(busy), 64'd0);
        chk("bp_b_count", 64'(vec_count), 64'(base + 16'd2));
        tick();
        chk("bp_valid_cleared", 64'(out_valid), 64'd0);

        // Abort during RUN: back to IDLE, no result.
        base = vec_count;
        send(2'b00, 5'd20, 24'h333333);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_flags", {61'd0, dut_clk_en, busy, in_ready}, 64'b001);
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        chk("abort_count", 64'(vec_count), 64'(base));
        chk("abort_mosi_kept", 64'(mosi_data), 64'h333333);

        // Abort with in_valid in IDLE: word not accepted.
        in_data  = {24'h999999, 5'd3, 2'b00};
        in_valid = 1'b1;
        abort    = 1'b1;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        chk("abort_idle_busy", 64'(busy), 64'd0);
        chk("abort_idle_mosi", 64'(mosi_data), 64'h333333);

        // Reset while a result is pending in HOLD.
        out_ready = 1'b0;
        miso_data = 24'hCCCCCC;
        send(2'b00, 5'd0, 24'h444444);
        wait_valid(10, lat);
        chk("rh_a_latency", 64'(lat), 64'd1);
        send(2'b00, 5'd1, 24'h555555);
        wait_hold(10, found);
        chk("rh_hold_reached", 64'(found), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rh_out_valid", 64'(out_valid), 64'd0);
        chk("rh_out_data", 64'(out_data), 64'd0);
        chk("rh_mosi", 64'(mosi_data), 64'd0);
        chk("rh_vec_count", 64'(vec_count), 64'd0);
        chk("rh_flags", {61'd0, dut_clk_en, busy, in_ready}, 64'b001);
        @(negedge clock);
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rh_lost_pending", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
